// File: rtl/sc_checker.sv
// Passive scoreboard for a 3-bit saturating counter: models the expected count and compares it every cycle.
// Latency: a failure seen in cycle N is reported on mismatch/fail/fail_cnt in cycle N+1.
// Backpressure: none; purely observes the counter's interface and never drives it.
module sc_checker #(
    parameter int SAT = 5,
    parameter int FCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctr_rst,
    input  logic [2:0]     cnt_in,
    input  logic           err_in,
    input  logic           chk_en,
    output logic           mismatch,
    output logic           fail,
    output logic [2:0]     first_exp,
    output logic [2:0]     first_obs,
    output logic [FCW-1:0] fail_cnt,
    output logic           saturated,
    output logic [1:0]     state
);

    localparam logic [2:0] SAT3 = 3'(SAT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2:0]     r_exp;
    logic [2:0]     w_exp_next;
    logic           r_saturated;
    logic           r_mismatch;
    logic           r_fail;
    logic [2:0]     r_first_exp;
    logic [2:0]     r_first_obs;
    logic [FCW-1:0] r_fail_cnt;
    logic           w_cmp;
    logic           w_illegal;
    logic           w_bad_obs;
    logic           w_fail;

    // Expected next count: clear on request, otherwise count up and stick at SAT.
    always_comb begin
        w_exp_next = r_exp;
        if (ctr_rst) begin
            w_exp_next = 3'd0;
        end else if (r_exp < SAT3) begin
            w_exp_next = r_exp + 3'd1;
        end else begin
            w_exp_next = SAT3;
        end
    end

    // Compare qualification and failure detection; IDLE absorbs the counter's own reset-exit cycle.
    always_comb begin
        w_cmp     = 1'b0;
        w_illegal = 1'b0;
        w_bad_obs = 1'b0;
        w_fail    = 1'b0;
        w_cmp     = (r_state != ST_IDLE) && chk_en;
        w_illegal = err_in || (cnt_in > SAT3);
        w_bad_obs = w_cmp && w_illegal;
        w_fail    = w_cmp && ((cnt_in != r_exp) || w_illegal);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; an illegal observation overrides the RUN/HOLD tracking.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_bad_obs) begin
                    w_state_next = ST_BAD;
                end else if ((w_exp_next == SAT3) && !ctr_rst) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_bad_obs) begin
                    w_state_next = ST_BAD;
                end else if (ctr_rst) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_BAD: begin
                if (ctr_rst && !w_bad_obs) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Count model and saturation flag track every non-reset cycle, independent of chk_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exp       <= 3'd0;
            r_saturated <= 1'b0;
        end else begin
            r_exp       <= w_exp_next;
            r_saturated <= (w_exp_next == SAT3);
        end
    end

    // Failure logging: pulse, sticky flag, first-failure capture and saturating tally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mismatch  <= 1'b0;
            r_fail      <= 1'b0;
            r_first_exp <= 3'd0;
            r_first_obs <= 3'd0;
            r_fail_cnt  <= '0;
        end else begin
            r_mismatch <= w_fail;
            if (w_fail && !r_fail) begin
                r_fail      <= 1'b1;
                r_first_exp <= r_exp;
                r_first_obs <= cnt_in;
            end
            if (w_fail && (r_fail_cnt != {FCW{1'b1}})) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
        end
    end

    assign mismatch  = r_mismatch;
    assign fail      = r_fail;
    assign first_exp = r_first_exp;
    assign first_obs = r_first_obs;
    assign fail_cnt  = r_fail_cnt;
    assign saturated = r_saturated;
    assign state     = r_state;

endmodule
